// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf - elastic pipeline-stage register for inter-stage
// boundaries (IF/ID, ID/EX, EX/MEM).
//
// Holds an opaque payload bundle behind a valid/ready handshake. With
// SKID=1 a second (skid) entry lets in_rdy come straight from a register,
// so no combinational path runs from out_rdy back to in_rdy. With SKID=0
// the stage is a single entry whose in_rdy passes out_rdy through.
// stall freezes everything; flush (when not stalled) empties the stage.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   in_en      upstream payload valid
//   in_rdy     stage can accept this cycle
//   in_data    upstream payload
//   stall      freeze: no transfer in or out, all state held
//   flush      discard all held entries
//   out_en     output payload valid
//   out_rdy    downstream accepts
//   out_data   output payload (NOP_DATA whenever out_en=0)
//   occupancy  number of valid entries (0..2)
//   bubble_cnt cycles where downstream was ready but nothing was offered
//   flush_cnt  flushes that actually discarded something
module pipe_stage_buf #(
    parameter int                 DATA_W   = 96,
    parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_en,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              move_ok;
    logic              in_xfer;
    logic              out_xfer;
    logic              bubble_hit;

    // Any transfer, in either direction, needs the stage to be neither
    // frozen nor being flushed.
    assign move_ok    = !stall && !flush;
    assign in_xfer    = in_en && in_rdy;
    assign out_xfer   = main_valid && out_rdy && move_ok;
    assign bubble_hit = out_rdy && !main_valid && move_ok;

    // The main entry is always the one presented downstream; keeping its
    // data at NOP_DATA when empty makes out_data a plain register output.
    assign out_en    = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // With a skid entry, ready only depends on whether the skid slot is
    // free, which is registered. Without one, an occupied main entry can
    // still accept if it is draining this same cycle.
    always_comb begin
        if (SKID != 0) begin
            in_rdy = !skid_valid && move_ok;
        end else begin
            in_rdy = (!main_valid || out_rdy) && move_ok;
        end
    end

    // Entry movement and counters. Stall freezes the whole block, which is
    // why it takes priority over flush. The skid entry is only ever filled
    // while main is held, so it is always the older of any incoming data
    // and refills main first to keep FIFO order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid <= 1'b0;
            main_data  <= NOP_DATA;
            skid_valid <= 1'b0;
            skid_data  <= NOP_DATA;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!stall) begin
            if (flush) begin
                main_valid <= 1'b0;
                main_data  <= NOP_DATA;
                skid_valid <= 1'b0;
                skid_data  <= NOP_DATA;
                if ((main_valid || skid_valid) && (flush_cnt != CNT_MAX)) begin
                    flush_cnt <= flush_cnt + CNT_ONE;
                end
            end else begin
                if (bubble_hit && (bubble_cnt != CNT_MAX)) begin
                    bubble_cnt <= bubble_cnt + CNT_ONE;
                end
                if (!main_valid || out_xfer) begin
                    if (skid_valid) begin
                        main_valid <= 1'b1;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        skid_data  <= NOP_DATA;
                    end else if (in_xfer) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                    end else begin
                        main_valid <= 1'b0;
                        main_data  <= NOP_DATA;
                    end
                end else if (in_xfer) begin
                    // Only reachable with SKID=1: main is held, park the
                    // new entry in the skid slot.
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf - bench for pipe_stage_buf.
//
// Three instances: a two-entry stage (main), a single-entry stage (single)
// and a two-entry stage with 2-bit counters (sat). main and sat share one
// set of upstream/downstream inputs; single has its own so its handshake
// can be exercised independently. reset, stall and flush are shared.
module tb_pipe_stage_buf;

    localparam int               DW  = 16;
    localparam logic [DW-1:0]    NOP = 16'hDEAD;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          flush;

    logic          in_en;
    logic [DW-1:0] in_data;
    logic          out_rdy;
    logic          s_in_en;
    logic [DW-1:0] s_in_data;
    logic          s_out_rdy;

    logic          m_in_rdy, m_out_en;
    logic [DW-1:0] m_out_data;
    logic [1:0]    m_occ;
    logic [15:0]   m_bubble, m_flush;

    logic          s_in_rdy, s_out_en;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occ;
    logic [15:0]   s_bubble, s_flush;

    logic          t_in_rdy, t_out_en;
    logic [DW-1:0] t_out_data;
    logic [1:0]    t_occ;
    logic [1:0]    t_bubble, t_flush;

    int            n_checks = 0;
    int            n_pass   = 0;

    logic [DW-1:0] sb_main[$];
    logic [DW-1:0] sb_single[$];

    pipe_stage_buf #(.DATA_W(DW), .NOP_DATA(NOP), .SKID(1), .CNT_W(16)) dut_main (
        .clk(clk), .reset(reset), .in_en(in_en), .in_rdy(m_in_rdy), .in_data(in_data),
        .stall(stall), .flush(flush), .out_en(m_out_en), .out_rdy(out_rdy),
        .out_data(m_out_data), .occupancy(m_occ), .bubble_cnt(m_bubble), .flush_cnt(m_flush)
    );

    pipe_stage_buf #(.DATA_W(DW), .NOP_DATA(NOP), .SKID(0), .CNT_W(16)) dut_single (
        .clk(clk), .reset(reset), .in_en(s_in_en), .in_rdy(s_in_rdy), .in_data(s_in_data),
        .stall(stall), .flush(flush), .out_en(s_out_en), .out_rdy(s_out_rdy),
        .out_data(s_out_data), .occupancy(s_occ), .bubble_cnt(s_bubble), .flush_cnt(s_flush)
    );

    pipe_stage_buf #(.DATA_W(DW), .NOP_DATA(NOP), .SKID(1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_en(in_en), .in_rdy(t_in_rdy), .in_data(in_data),
        .stall(stall), .flush(flush), .out_en(t_out_en), .out_rdy(out_rdy),
        .out_data(t_out_data), .occupancy(t_occ), .bubble_cnt(t_bubble), .flush_cnt(t_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle's inputs. A side that is not targeted is left idle
    // (no valid, not ready); stall and flush always reach every instance.
    task automatic applyStimulus(input bit to_main, input bit to_single, input logic en,
                                 input logic [DW-1:0] data, input logic ordy,
                                 input logic st, input logic fl);
        stall = st;
        flush = fl;
        in_en     = to_main   ? en   : 1'b0;
        in_data   = to_main   ? data : '0;
        out_rdy   = to_main   ? ordy : 1'b0;
        s_in_en   = to_single ? en   : 1'b0;
        s_in_data = to_single ? data : '0;
        s_out_rdy = to_single ? ordy : 1'b0;
    endtask

    // Advance to just after the next active edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the two-entry stage: record accepted payloads, check
    // each output transfer against the oldest one, and drop everything on
    // flush or reset. Sampled on the falling edge, away from the update.
    always @(negedge clk) begin
        if (!reset) begin
            sb_main.delete();
        end else if (!stall) begin
            if (flush) begin
                sb_main.delete();
            end else begin
                if (!m_out_en) checkOutput("main_nop_when_idle", 32'(m_out_data), 32'(NOP));
                if (m_out_en && out_rdy) begin
                    if (sb_main.size() == 0) checkOutput("main_unexpected_out", 32'(m_out_data), 32'(NOP));
                    else checkOutput("main_order", 32'(m_out_data), 32'(sb_main.pop_front()));
                end
                if (in_en && m_in_rdy) sb_main.push_back(in_data);
            end
        end
    end

    // Same scoreboard for the single-entry stage.
    always @(negedge clk) begin
        if (!reset) begin
            sb_single.delete();
        end else if (!stall) begin
            if (flush) begin
                sb_single.delete();
            end else begin
                if (!s_out_en) checkOutput("single_nop_when_idle", 32'(s_out_data), 32'(NOP));
                if (s_out_en && s_out_rdy) begin
                    if (sb_single.size() == 0) checkOutput("single_unexpected_out", 32'(s_out_data), 32'(NOP));
                    else checkOutput("single_order", 32'(s_out_data), 32'(sb_single.pop_front()));
                end
                if (s_in_en && s_in_rdy) sb_single.push_back(s_in_data);
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);

        // Reset held two cycles with valid input present.
        cycle();
        cycle();
        checkOutput("rst_out_en", 32'(m_out_en), 32'd0);
        checkOutput("rst_out_data", 32'(m_out_data), 32'(NOP));
        checkOutput("rst_occ", 32'(m_occ), 32'd0);
        checkOutput("rst_bubble", 32'(m_bubble), 32'd0);
        checkOutput("rst_flush", 32'(m_flush), 32'd0);
        checkOutput("rst_single_out_en", 32'(s_out_en), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rel_in_rdy", 32'(m_in_rdy), 32'd1);
        checkOutput("rel_single_in_rdy", 32'(s_in_rdy), 32'd1);

        // Counter saturation with idle, ready downstream.
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            checkOutput("sat_bubble", 32'(t_bubble), (i < 3) ? 32'(i) : 32'd3);
        end
        checkOutput("main_bubble_5", 32'(m_bubble), 32'd5);

        // Second reset to clear counters.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        reset = 1'b1;
        checkOutput("rst2_bubble", 32'(m_bubble), 32'd0);
        checkOutput("rst2_sat_bubble", 32'(t_bubble), 32'd0);

        // Streaming 1..8 with downstream always ready.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("stream_in_rdy", 32'(m_in_rdy), 32'd1);
            if (k == 1) begin
                checkOutput("stream_first_empty", 32'(m_out_en), 32'd0);
            end else begin
                checkOutput("stream_data", 32'(m_out_data), 32'(k - 1));
                checkOutput("stream_occ", 32'(m_occ), 32'd1);
            end
            cycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("stream_last", 32'(m_out_data), 32'd8);
        checkOutput("stream_bubble", 32'(m_bubble), 32'd1);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle();

        // Backpressure on the two-entry stage: A, B accepted, C held.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("bp_a_rdy", 32'(m_in_rdy), 32'd1);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("bp_b_rdy", 32'(m_in_rdy), 32'd1);
        checkOutput("bp_b_occ", 32'(m_occ), 32'd1);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("bp_c_blocked", 32'(m_in_rdy), 32'd0);
        checkOutput("bp_occ2", 32'(m_occ), 32'd2);
        checkOutput("bp_head", 32'(m_out_data), 32'h000A);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("bp_rdy_registered", 32'(m_in_rdy), 32'd0);
        checkOutput("bp_out_a", 32'(m_out_data), 32'h000A);
        cycle();
        #1; checkOutput("bp_c_rdy", 32'(m_in_rdy), 32'd1);
        checkOutput("bp_out_b", 32'(m_out_data), 32'h000B);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("bp_out_c", 32'(m_out_data), 32'h000C);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("bp_drained", 32'(m_occ), 32'd0);

        // Backpressure on the single-entry stage.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("sgl_a_rdy", 32'(s_in_rdy), 32'd1);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("sgl_b_blocked", 32'(s_in_rdy), 32'd0);
        checkOutput("sgl_occ", 32'(s_occ), 32'd1);
        s_out_rdy = 1'b1;
        #1; checkOutput("sgl_rdy_follows", 32'(s_in_rdy), 32'd1);
        s_out_rdy = 1'b0;
        #1; checkOutput("sgl_rdy_drops", 32'(s_in_rdy), 32'd0);
        cycle();
        #1; checkOutput("sgl_hold_a", 32'(s_out_data), 32'h000A);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h000B, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("sgl_b_rdy", 32'(s_in_rdy), 32'd1);
        checkOutput("sgl_out_a", 32'(s_out_data), 32'h000A);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("sgl_out_b", 32'(s_out_data), 32'h000B);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("sgl_out_c", 32'(s_out_data), 32'h000C);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle();

        // Stall with two entries held; flush in the middle is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b1, (s == 1));
            #1;
            checkOutput("stall_occ", 32'(m_occ), 32'd2);
            checkOutput("stall_data", 32'(m_out_data), 32'h000D);
            checkOutput("stall_in_rdy", 32'(m_in_rdy), 32'd0);
            checkOutput("stall_bubble", 32'(m_bubble), 32'd1);
            checkOutput("stall_flush_cnt", 32'(m_flush), 32'd0);
            cycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1; checkOutput("unstall_occ", 32'(m_occ), 32'd2);
        checkOutput("unstall_d", 32'(m_out_data), 32'h000D);
        cycle();
        #1; checkOutput("unstall_e", 32'(m_out_data), 32'h000E);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("unstall_drained", 32'(m_occ), 32'd0);

        // Flush with two entries held, then a flush while empty.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b1);
        #1; checkOutput("flush_in_rdy", 32'(m_in_rdy), 32'd0);
        checkOutput("flush_pre_occ", 32'(m_occ), 32'd2);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("flush_out_en", 32'(m_out_en), 32'd0);
        checkOutput("flush_out_data", 32'(m_out_data), 32'(NOP));
        checkOutput("flush_occ", 32'(m_occ), 32'd0);
        checkOutput("flush_cnt_1", 32'(m_flush), 32'd1);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1; checkOutput("flush_empty_cnt", 32'(m_flush), 32'd1);
        checkOutput("flush_empty_occ", 32'(m_occ), 32'd0);
        checkOutput("final_bubble", 32'(m_bubble), 32'd1);
        cycle();

        checkOutput("sb_main_empty", 32'(sb_main.size()), 32'd0);
        checkOutput("sb_single_empty", 32'(sb_single.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic pipeline-stage register for inter-stage boundaries such as IF/ID, ID/EX and EX/MEM.
- Successor to the fixed stall/flush stage registers.
- Carries an arbitrary-width payload bundle (pc, ops, operands, exception code, packed by the instantiator).
- Adds a valid/ready handshake, an optional 2-entry skid buffer that breaks the ready path, an occupancy output and saturating performance counters.
- Keeps stall-freeze and flush-to-NOP semantics.

Parameters:
DATA_W, 96, payload width in bits.
NOP_DATA, {DATA_W{1'b0}}, payload value driven when the stage holds no valid entry.
SKID, 1, 1 = two entries (main + skid) with in_rdy registered; 0 = single entry with combinational in_rdy.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is synchronous and active-low
in_en  in  1  upstream payload valid
in_rdy  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
stall  in  1  freeze: no transfer in or out, all state held
flush  in  1  discard all held entries
out_en  out  1  output payload valid
out_rdy  in  1  downstream accepts
out_data  out  DATA_W  output payload
occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0)
bubble_cnt  out  CNT_W  cycles with out_rdy=1, out_en=0, stall=0, flush=0
flush_cnt  out  CNT_W  flushes that discarded at least one valid entry

Behaviour:
Reset
- Sampled at posedge clk when reset==0.
- Result: main and skid invalid; out_en=0; out_data=NOP_DATA; occupancy=0; both counters=0.
- Reset overrides stall and flush.
- Reset mid-transfer drops all entries; nothing is replayed.

Handshake
- Input transfer: in_en & in_rdy.
- Output transfer: out_en & out_rdy & !stall & !flush.
- Upstream holds in_data stable while in_en=1 and in_rdy=0.
- Latency is 1 cycle from input transfer to out_en=1 when the stage is empty.
- Strict FIFO order; no loss or duplication.

in_rdy
- SKID=1: in_rdy = !skid_valid & !stall & !flush. This is a registered term gated only by stall/flush; there is no path from out_rdy.
- SKID=0: in_rdy = (!main_valid | out_rdy) & !stall & !flush.

Entry movement (stall=0, flush=0)
- Main empty, or main leaving with skid empty: input goes to main.
- Main full and not leaving (SKID=1): input goes to skid.
- Main leaving with skid full: skid moves to main, and the skid becomes empty.
- Main leaving with no replacement: main_valid=0 and main data reloads NOP_DATA.
- Result: out_data==NOP_DATA whenever out_en=0.

Stall
- stall=1 has priority over flush, matching the existing stage registers.
- Nothing changes while stalled: no transfer in or out, flush ignored, counters held.

Flush (stall=0)
- Next cycle: all entries invalid, out_data=NOP_DATA, occupancy=0.
- in_rdy=0 in the flush cycle, so nothing is accepted.
- Any out_en/out_rdy coincidence in the flush cycle is not a transfer; downstream receives the same flush.
- flush_cnt increments only if occupancy was nonzero.

Counters
- Unsigned, saturate at all-ones, cleared only by reset.

occupancy
- Equals main_valid + skid_valid, updated with the entries.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_en=1, in_data=0x5 -> out_en=0, out_data=NOP_DATA, occupancy=0, counters=0; in_rdy=1 in the first cycle after release.
- Streaming (SKID=1): out_rdy=1, in_en=1 with data 1..8 on consecutive cycles -> out_data 1..8, each one cycle after acceptance, no gaps; occupancy=1 throughout; bubble_cnt=1 (first cycle only).
- Backpressure (SKID=1): out_rdy=0, send A, B, C -> A and B accepted, in_rdy=0 after B, occupancy=2, C held; raise out_rdy -> A, B, C emerge in order, no duplication. The same sequence with SKID=0 -> only A is held, and in_rdy follows out_rdy combinationally.
- Stall: occupancy=2, stall=1 for 3 cycles with in_en=1, out_rdy=1 and flush=1 in the middle cycle -> outputs frozen, occupancy stays 2, flush ignored, counters unchanged; transfers resume on the cycle after stall drops.
- Flush: occupancy=2, flush=1 with in_en=1 and data 0x9 -> next cycle out_en=0, out_data=NOP_DATA, occupancy=0, flush_cnt=1, 0x9 not accepted. A second flush while empty -> flush_cnt stays 1.
- Saturation (CNT_W=2): 5 idle cycles with out_rdy=1 -> bubble_cnt=3 and held there.
